fetch_stage: RTL and testbench

Instruction-fetch front end that generates the PC, issues requests to instruction memory and delivers {instruction, PC} pairs to the IF/ID pipeline register. It is the producer side of the IF/ID interface. It drives Instruction_IF/PC_Addr_IF and honours the same stall signal that freezes IF/ID. It contains a 2-entry fetch buffer so an in-flight memory response is never lost while the pipeline is stalled, and it accepts branch/jump redirects from ID.

---
 rtl/fetch_stage_if.sv | 10 +
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC generation, imem requests, 2-entry fetch buffer
// feeding the IF/ID register, with redirect flush and stale-response dropping.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] INST_NOP = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic [31:0]          Instruction_IF,
    output logic [31:0]          PC_Addr_IF,
    output logic                 fetch_valid
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 2;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   drop_addr;
    logic [XLEN-1:0]   inst_q [2];
    logic [XLEN-1:0]   pc_q   [2];
    logic [CW-1:0]     count;

    logic              pop;
    logic              push;
    logic              wr_idx;
    logic [CW-1:0]     count_next;

    assign fetch_valid    = (count != CW'(0));
    assign Instruction_IF = fetch_valid ? inst_q[0] : INST_NOP;
    assign PC_Addr_IF     = fetch_valid ? pc_q[0]   : XLEN'(0);

    assign imem.imem_req  = (state != IDLE);
    assign imem.imem_addr = (state == DROP) ? drop_addr : pc;

    assign pop        = fetch_valid && !stall && !redirect;
    assign push       = (state == REQ) && imem.imem_ack && !redirect;
    assign count_next = CW'(count - CW'(pop) + CW'(push));
    // Push lands in slot 1 only if the existing head survives this cycle.
    assign wr_idx     = (count == CW'(1)) && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REQ;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            count     <= CW'(0);
            inst_q[0] <= XLEN'(0);
            inst_q[1] <= XLEN'(0);
            pc_q[0]   <= XLEN'(0);
            pc_q[1]   <= XLEN'(0);
        end else if (redirect) begin
            count <= CW'(0);
            pc    <= redirect_pc;
            case (state)
                REQ: begin
                    if (imem.imem_ack) begin
                        state <= REQ;
                    end else begin
                        // Outstanding request must stay stable until its ack.
                        drop_addr <= pc;
                        state     <= DROP;
                    end
                end
                IDLE:    state <= REQ;
                DROP:    state <= imem.imem_ack ? REQ : DROP;
                default: state <= REQ;
            endcase
        end else begin
            count <= count_next;
            if (pop) begin
                inst_q[0] <= inst_q[1];
                pc_q[0]   <= pc_q[1];
            end
            if (push) begin
                inst_q[wr_idx] <= imem.imem_rdata;
                pc_q[wr_idx]   <= pc;
                pc             <= pc + XLEN'(4);
            end
            case (state)
                REQ: begin
                    if (push && count_next == CW'(2)) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (pop) begin
                        state <= REQ;
                    end
                end
                DROP: begin
                    if (imem.imem_ack) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences
// for reset/wrap corners, and randomized traffic against a queue-based model.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] INST_NOP = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] Instruction_IF;
    logic [31:0] PC_Addr_IF;
    logic        fetch_valid;

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(RESET_PC), .INST_NOP(INST_NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem           (imem.master),
        .Instruction_IF (Instruction_IF),
        .PC_Addr_IF     (PC_Addr_IF),
        .fetch_valid    (fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        ev;
        logic [31:0] einst;
        logic [31:0] epc;
        logic        ereq;
        logic [31:0] eaddr;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic a, input logic [31:0] rd, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic eq, input logic [31:0] ea);
        vec_t v;
        v.stall = s; v.redirect = r; v.rpc = rpc; v.ack = a; v.rdata = rd;
        v.ev = ev; v.einst = ei; v.epc = ep; v.ereq = eq; v.eaddr = ea;
        return v;
    endfunction

    vec_t vt [14];

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq [$];
    logic [31:0] m_next_pc;
    logic [31:0] m_stale_addr;
    bit          m_dropping;

    function automatic void model_reset();
        mq.delete();
        m_next_pc    = RESET_PC;
        m_stale_addr = RESET_PC;
        m_dropping   = 1'b0;
    endfunction

    // Fetcher asks memory whenever it owes a stale response or has buffer room.
    function automatic bit m_req();
        return m_dropping || (mq.size() < 2);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_dropping ? m_stale_addr : m_next_pc;
    endfunction

    function automatic void model_step(input logic s, input logic r, input logic [31:0] rpc,
                                       input logic a, input logic [31:0] rd);
        bit req_now;
        bit done;
        req_now = m_req();
        done    = req_now && a;
        if (r) begin
            if (!m_dropping && req_now && !a) begin
                m_dropping   = 1'b1;
                m_stale_addr = m_next_pc;
            end else if (m_dropping && a) begin
                m_dropping = 1'b0;
            end
            mq.delete();
            m_next_pc = rpc;
        end else if (m_dropping) begin
            if (a) m_dropping = 1'b0;
            if (mq.size() != 0 && !s) void'(mq.pop_front());
        end else begin
            if (mq.size() != 0 && !s) void'(mq.pop_front());
            if (done) begin
                mq.push_back('{inst: rd, pc: m_next_pc});
                m_next_pc = m_next_pc + 32'd4;
            end
        end
    endfunction

    task automatic compare_model();
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        ev = (mq.size() != 0);
        ei = ev ? mq[0].inst : INST_NOP;
        ep = ev ? mq[0].pc   : 32'd0;
        chk("rnd_valid", 32'(fetch_valid), 32'(ev));
        chk("rnd_inst",  Instruction_IF, ei);
        chk("rnd_pc",    PC_Addr_IF, ep);
        chk("rnd_req",   32'(imem.imem_req), 32'(m_req()));
        if (m_req()) chk("rnd_addr", imem.imem_addr, m_addr());
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rpc,
                         input logic a, input logic [31:0] rd);
        stall = s; redirect = r; redirect_pc = rpc;
        imem.imem_ack = a; imem.imem_rdata = rd;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        rst = 1'b1;

        vt[0]  = mk(0, 0, 32'h0,    1, 32'h11, 1, 32'h11, 32'h3000, 1, 32'h3004);
        vt[1]  = mk(0, 0, 32'h0,    1, 32'h22, 1, 32'h22, 32'h3004, 1, 32'h3008);
        vt[2]  = mk(1, 0, 32'h0,    1, 32'h33, 1, 32'h22, 32'h3004, 0, 32'h0);
        vt[3]  = mk(1, 0, 32'h0,    1, 32'h44, 1, 32'h22, 32'h3004, 0, 32'h0);
        vt[4]  = mk(0, 0, 32'h0,    0, 32'h0,  1, 32'h33, 32'h3008, 1, 32'h300C);
        vt[5]  = mk(0, 0, 32'h0,    0, 32'h0,  0, INST_NOP, 32'h0,  1, 32'h300C);
        vt[6]  = mk(0, 0, 32'h0,    0, 32'h0,  0, INST_NOP, 32'h0,  1, 32'h300C);
        vt[7]  = mk(0, 0, 32'h0,    1, 32'h55, 1, 32'h55, 32'h300C, 1, 32'h3010);
        vt[8]  = mk(1, 1, 32'h3100, 0, 32'h0,  0, INST_NOP, 32'h0,  1, 32'h3010);
        vt[9]  = mk(0, 0, 32'h0,    0, 32'h0,  0, INST_NOP, 32'h0,  1, 32'h3010);
        vt[10] = mk(0, 0, 32'h0,    1, 32'h66, 0, INST_NOP, 32'h0,  1, 32'h3100);
        vt[11] = mk(0, 0, 32'h0,    1, 32'h77, 1, 32'h77, 32'h3100, 1, 32'h3104);
        vt[12] = mk(1, 1, 32'h3200, 1, 32'h88, 0, INST_NOP, 32'h0,  1, 32'h3200);
        vt[13] = mk(0, 0, 32'h0,    1, 32'h99, 1, 32'h99, 32'h3200, 1, 32'h3204);

        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_inst",  Instruction_IF, INST_NOP);
        chk("rst_pc",    PC_Addr_IF, 32'd0);
        chk("rst_req",   32'(imem.imem_req), 32'd1);
        chk("rst_addr",  imem.imem_addr, RESET_PC);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].stall, vt[i].redirect, vt[i].rpc, vt[i].ack, vt[i].rdata);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(fetch_valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d_inst", i),  Instruction_IF, vt[i].einst);
            chk($sformatf("vec%0d_pc", i),    PC_Addr_IF, vt[i].epc);
            chk($sformatf("vec%0d_req", i),   32'(imem.imem_req), 32'(vt[i].ereq));
            if (vt[i].ereq) chk($sformatf("vec%0d_addr", i), imem.imem_addr, vt[i].eaddr);
        end

        // Reset asserted while a stale request is being dropped
        do_reset();
        drive(0, 0, 32'h0, 1, 32'hAB);
        @(posedge clk); #1;
        drive(0, 1, 32'h3400, 0, 32'h0);
        @(posedge clk); #1;
        chk("drop_addr",  imem.imem_addr, 32'h3004);
        chk("drop_valid", 32'(fetch_valid), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(fetch_valid), 32'd0);
        chk("midrst_inst",  Instruction_IF, INST_NOP);
        chk("midrst_pc",    PC_Addr_IF, 32'd0);
        chk("midrst_req",   32'(imem.imem_req), 32'd1);
        chk("midrst_addr",  imem.imem_addr, RESET_PC);
        drive(0, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 32'h0, 1, 32'hCD);
        @(posedge clk); #1;
        chk("restart_pc",   PC_Addr_IF, 32'h3000);
        chk("restart_inst", Instruction_IF, 32'hCD);
        chk("restart_addr", imem.imem_addr, 32'h3004);

        // PC wraps modulo 2^32
        drive(0, 1, 32'hFFFF_FFFC, 1, 32'h0);
        @(posedge clk); #1;
        chk("wrap_addr0", imem.imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 32'h0, 1, 32'hA1);
        @(posedge clk); #1;
        chk("wrap_pc0",   PC_Addr_IF, 32'hFFFF_FFFC);
        chk("wrap_addr1", imem.imem_addr, 32'h0);
        drive(0, 0, 32'h0, 1, 32'hA2);
        @(posedge clk); #1;
        chk("wrap_pc1",   PC_Addr_IF, 32'h0);
        chk("wrap_inst1", Instruction_IF, 32'hA2);

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        #1;
        compare_model();
        for (int c = 0; c < 3000; c++) begin
            logic        s;
            logic        r;
            logic        a;
            logic [31:0] rpc;
            logic [31:0] rd;
            s   = ($urandom_range(0, 9) < 3);
            r   = ($urandom_range(0, 19) == 0);
            a   = ($urandom_range(0, 9) < 6);
            rpc = $urandom() & 32'hFFFF_FFFC;
            rd  = $urandom();
            drive(s, r, rpc, a, rd);
            @(posedge clk);
            model_step(s, r, rpc, a, rd);
            #1;
            compare_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
